// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op encodings presented on alu_muldiv_unit.op
//   - FSM state encoding (IDLE / RUN / FIX)
//   - helper that derives the iteration-counter width from the operand width
// Configuration macro affecting users of this package: ALU_MULDIV_FAST_MUL_EN
// (see alu_muldiv_unit).
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Counter must hold 0..w-1; a width of at least one bit is kept so the
    // degenerate w<=2 case still elaborates.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/alu_muldiv_unit_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem_i      partial remainder entering this iteration (always < divisor)
//   bit_i      next dividend bit shifted into the remainder
//   divisor_i  divisor magnitude
//   rem_o      partial remainder leaving this iteration
//   q_o        quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        // When the subtract succeeds the true difference is below the divisor,
        // so the low WIDTH bits of the modular difference are exact.
        diff    = shifted[WIDTH-1:0] - divisor_i;
        rem_o   = q_o ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// ----------------------------------------------------------------------------
// alu_muldiv_unit
// Iterative multiply/divide unit for the EX stage with architectural HI/LO.
// MULT/MULTU/DIV/DIVU run one step per cycle (WIDTH steps) followed by a
// sign-fix cycle; MTHI/MTLO write in a single cycle from IDLE.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset (overrides start and flush)
//   start  issue strobe, only looked at while busy=0
//   op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a      rs operand (dividend / multiplicand / MTHI-MTLO source)
//   b      rt operand (divisor / multiplier)
//   flush  abort any in-flight operation; nothing is written
//   busy   operation in flight, EX must stall dependents
//   done   one-cycle pulse, hi/lo were just updated
//   hi     HI register (product upper half / remainder)
//   lo     LO register (product lower half / quotient)
//
// Optional feature: define ALU_MULDIV_FAST_MUL_EN to complete MULT/MULTU in
// the issuing cycle with a combinational multiplier; divides are unaffected.
// ----------------------------------------------------------------------------
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------
    logic mul_req, div_req, iter_req, signed_op;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        mul_req   = (op == OP_MULT) || (op == OP_MULTU);
        div_req   = (op == OP_DIV)  || (op == OP_DIVU);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
`ifdef ALU_MULDIV_FAST_MUL_EN
        iter_req  = div_req;
`else
        iter_req  = div_req || mul_req;
`endif
        a_neg = signed_op && a[WIDTH-1];
        b_neg = signed_op && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_iter, step_en, commit, wr_hi, wr_lo, fast_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush && start && iter_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        logic accept;
        accept    = (state_q == IDLE) && start && !flush;
        busy      = (state_q != IDLE);
        load_iter = accept && iter_req;
        step_en   = (state_q == RUN) && !flush;
        commit    = (state_q == FIX) && !flush;
        wr_hi     = accept && (op == OP_MTHI);
        wr_lo     = accept && (op == OP_MTLO);
`ifdef ALU_MULDIV_FAST_MUL_EN
        fast_wr   = accept && mul_req;
`else
        fast_wr   = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Datapath
    //   acc_q  : product upper half (mul) / partial remainder (div)
    //   work_q : multiplier shifting out, product lower half shifting in
    //            (mul) / dividend shifting out, quotient shifting in (div)
    //   opnd_q : multiplicand magnitude (mul) / divisor magnitude (div)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (acc_q),
        .bit_i    (work_q[WIDTH-1]),
        .divisor_i(opnd_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    logic [2*WIDTH-1:0] ext_a, ext_b;

    // Sign- or zero-extend to full product width; the low 2*WIDTH bits of
    // the unsigned product of the extended operands are then correct for
    // both signednesses.
    always_comb begin
        if (op == OP_MULT) begin
            ext_a = {{WIDTH{a[WIDTH-1]}}, a};
            ext_b = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            ext_a = {{WIDTH{1'b0}}, a};
            ext_b = {{WIDTH{1'b0}}, b};
        end
        fast_prod = ext_a * ext_b;
    end
`endif

    always_comb begin
        mul_sum  = {1'b0, acc_q} + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
        prod_fix = neg_res_q ? -{acc_q, work_q} : {acc_q, work_q};
        quo_fix  = neg_res_q ? -work_q : work_q;
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        acc_d     = acc_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        if (load_iter) begin
            cnt_d     = '0;
            acc_d     = '0;
            a_raw_d   = a;
            is_div_d  = div_req;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = (b == '0);
            if (div_req) begin
                work_d = a_mag;
                opnd_d = b_mag;
            end else begin
                work_d = b_mag;
                opnd_d = a_mag;
            end
        end else if (step_en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (is_div_q) begin
                acc_d  = step_rem;
                work_d = {work_q[WIDTH-2:0], step_q};
            end else begin
                acc_d  = mul_sum[WIDTH:1];
                work_d = {mul_sum[0], work_q[WIDTH-1:1]};
            end
        end else if (commit) begin
            done_d = 1'b1;
            if (!is_div_q) begin
                {hi_d, lo_d} = prod_fix;
            end else if (div0_q) begin
                hi_d = a_raw_q;
                lo_d = '1;
            end else begin
                // The most-negative / -1 overflow falls out naturally: the
                // quotient magnitude 2^(WIDTH-1) is left un-negated and the
                // remainder is zero.
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end else if (wr_hi) begin
            hi_d   = a;
            done_d = 1'b1;
        end else if (wr_lo) begin
            lo_d   = a;
            done_d = 1'b1;
        end else if (fast_wr) begin
`ifdef ALU_MULDIV_FAST_MUL_EN
            {hi_d, lo_d} = fast_prod;
`endif
            done_d = 1'b1;
        end

        if (flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_muldiv_unit
// Directed bench for alu_muldiv_unit. A cycle-level reference model built
// from plain arithmetic predicts busy/done/hi/lo every cycle; directed cases
// additionally pin results and latencies to hand-computed literals.
// Honours ALU_MULDIV_FAST_MUL_EN when defined for the build.
// ----------------------------------------------------------------------------
module tb_alu_muldiv_unit;

    localparam int W = 32;

`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam bit FAST    = 1'b1;
    localparam int MUL_LAT = 0;
`else
    localparam bit FAST    = 1'b0;
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .flush(flush),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking helper
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: arithmetic result of one op, returned as {hi, lo}
    // ------------------------------------------------------------------
    function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
        int        ix, iy;
        longint    sp;
        logic [2*W-1:0] r;
        ix = x;
        iy = y;
        r  = '0;
        case (o)
            3'd0: begin
                sp = longint'(ix) * longint'(iy);
                r  = sp;
            end
            3'd1: r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            3'd2: begin
                if (y == 0)                                   r = {x, {W{1'b1}}};
                else if (x == 32'h8000_0000 && y == '1)       r = {{W{1'b0}}, 32'h8000_0000};
                else                                          r = {W'(ix % iy), W'(ix / iy)};
            end
            3'd3: begin
                if (y == 0) r = {x, {W{1'b1}}};
                else        r = {x % y, x / y};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycle-level model state: pending results waiting out the latency.
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;
    int             m_left = 0;
    bit             m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (flush) begin
                    m_left = 0;
                    exp_q.delete();
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = exp_q.pop_front();
                        m_done = 1'b1;
                    end
                end
            end else if (start && !flush) begin
                if (op <= 3'd3) begin
                    if (FAST && op <= 3'd1) begin
                        {m_hi, m_lo} = ref_result(op, a, b);
                        m_done = 1'b1;
                    end else begin
                        exp_q.push_back(ref_result(op, a, b));
                        m_left = W + 1;
                    end
                end else if (op == 3'd4) begin
                    m_hi   = a;
                    m_done = 1'b1;
                end else if (op == 3'd5) begin
                    m_lo   = a;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", W'(busy), W'(m_left > 0));
            check("cyc_done", W'(done), W'(m_done));
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the negedge right after the issuing edge; counts negedges
    // until done is seen, and how many of them showed busy.
    task automatic wait_done(input string name, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({name, "_done_seen"}, W'(done), W'(1));
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] e_hi,
                         input logic [W-1:0] e_lo, input int e_lat);
        int lat, bcnt;
        issue(o, x, y);
        wait_done(name, lat, bcnt);
        check({name, "_hi"}, hi, e_hi);
        check({name, "_lo"}, lo, e_lo);
        check({name, "_lat"}, W'(lat), W'(e_lat));
        check({name, "_busycnt"}, W'(bcnt), W'(e_lat));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int lat, bcnt;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        rst = 1'b0;
        @(negedge clk);

        do_op("multu",    3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
        do_op("mult",     3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mult_nn",  3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, MUL_LAT);
        do_op("div",      3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        do_op("div_pn",   3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT);
        do_op("divu0",    3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, DIV_LAT);
        do_op("div0s",    3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);
        do_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
        do_op("divu",     3'd3, 32'd1000,      32'd7,         32'd6,         32'd142,       DIV_LAT);
        do_op("multu67",  3'd1, 32'd6,         32'd7,         32'd0,         32'd42,        MUL_LAT);
        do_op("mthi",     3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'd42,        0);
        do_op("mtlo",     3'd5, 32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0);

        // Flush mid-RUN.
        issue(3'd3, 32'h100, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_busy", W'(busy), '0);
        repeat (3) @(negedge clk);
        check("flush_run_hi", hi, 32'h0000_1234);
        check("flush_run_lo", lo, 32'h0000_5678);

        // Flush landing in the sign-fix cycle.
        issue(3'd3, 32'd50, 32'd5);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_fix_busy", W'(busy), '0);
        check("flush_fix_done", W'(done), '0);
        repeat (2) @(negedge clk);
        check("flush_fix_hi", hi, 32'h0000_1234);
        check("flush_fix_lo", lo, 32'h0000_5678);

        // Flush and start together in IDLE: start dropped.
        flush = 1'b1;
        issue(3'd3, 32'd9, 32'd3);
        flush = 1'b0;
        check("flush_start_busy", W'(busy), '0);
        repeat (2) @(negedge clk);
        check("flush_start_lo", lo, 32'h0000_5678);

        // Start while busy is ignored.
        issue(3'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(3'd1, 32'd9, 32'd9);
        wait_done("busy_start", lat, bcnt);
        check("busy_start_lat", W'(lat), W'(28));
        check("busy_start_hi", hi, 32'd2);
        check("busy_start_lo", lo, 32'd14);
        @(negedge clk);

        // No-op encodings.
        issue(3'd6, 32'hDEAD_BEEF, 32'd1);
        issue(3'd7, 32'hDEAD_BEEF, 32'd1);
        repeat (2) @(negedge clk);
        check("noop_busy", W'(busy), '0);
        check("noop_hi", hi, 32'd2);
        check("noop_lo", lo, 32'd14);

        // Reset in the middle of RUN.
        issue(3'd3, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_busy", W'(busy), '0);
        check("rst_run_hi", hi, '0);
        check("rst_run_lo", lo, '0);
        @(negedge clk);

        do_op("post_rst", 3'd3, 32'd1000, 32'd3, 32'd1, 32'd333, DIV_LAT);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; successor to the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers.
- Also executes single-cycle MTHI and MTLO.
- Exposes busy so the hazard unit stalls MFHI/MFLO and further mul/div issue until the result is ready.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  issue strobe from EX; sampled only when busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=no-op.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort in-flight operation (branch/exception squash).
- busy  output  1  operation in flight; EX must stall dependent instructions.
- done  output  1  one-cycle pulse: hi/lo updated by a completed op.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. rst overrides start and flush in the same cycle.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN: start=1 with op 0-3. Latch operands; for signed ops, latch magnitudes plus sign bits.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; counter counts 0..WIDTH-1. RUN -> FIX after WIDTH steps.
  - FIX: apply sign correction and write hi/lo. Assert done for that cycle. FIX -> IDLE.
- Latency: start accepted at edge k; busy=1 from edge k; hi/lo/done update at edge k+WIDTH+1, where busy also returns to 0. A new start may be accepted at edge k+WIDTH+1.
- MTHI/MTLO: accepted in IDLE only. Write hi (or lo) with a at edge k, pulse done; busy stays 0. The other register is unchanged.
- op 6-7 with start: ignored, no done.
- start while busy=1: ignored; the in-flight op continues.
- MULT/MULTU: {hi,lo} = 2*WIDTH-bit product. MULT is signed: result negated when sign(a)^sign(b).
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed quotient sign = sign(a)^sign(b); remainder takes the sign of a (truncation toward zero).
- Divide by zero, any signedness: lo = all ones, hi = a unchanged. Same latency as a normal divide.
- Signed overflow DIV(most-negative, -1): lo = most-negative, hi = 0.
- flush=1: any state -> IDLE at next edge, busy=0, no done, hi/lo keep their pre-op values.
  - flush and start in the same IDLE cycle: flush wins, start dropped.
  - flush in the FIX cycle: write suppressed.
- No partial results are ever visible on hi/lo.

Optional Feature:
- Macro: ALU_MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU complete in a single cycle via combinational multiply. hi/lo written and done pulsed at edge k; busy never asserts for multiplies. Divides are unchanged.
- Undefined: multiplies use the iterative RUN/FIX path with WIDTH+1 latency.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings: OP_MULT..OP_MTLO
  - FSM state enum: IDLE/RUN/FIX
  - a WIDTH-derived counter-width constant: clog2(WIDTH)
- One natural sub-module: div_step, a combinational single restoring-division iteration (partial remainder, divisor -> next remainder, quotient bit), instantiated once in the datapath.

Test Plan:
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0x00000002 -> after 33 cycles hi=0x00000001, lo=0xFFFFFFFE, done one cycle, busy 1 for exactly 33 cycles.
- Signed multiply and divide:
  - MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide corner cases:
  - DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Flush mid-op:
  - Preload via MTHI 0x1234, MTLO 0x5678 (each single-cycle, busy=0).
  - Start DIVU, flush at cycle 10 -> busy 0 next cycle, no done, hi=0x1234, lo=0x5678.
- Issue rules:
  - start with MULTU while busy -> ignored; the first result is unaffected.
  - rst asserted mid-RUN -> hi=lo=0, busy=0 next edge.
- With ALU_MULDIV_FAST_MUL_EN:
  - MULTU 6x7 -> lo=42, hi=0, done at the issuing edge, busy never 1.
  - DIVU still takes 33 cycles.
